// File: rtl/vregfile_banked.sv
// Banked vector register file: NUM_REGS x VLEN storage streamed in LANE_WIDTH beats
// over NUM_RD flow-controlled read ports and one byte-enabled write port with hazard interlocks.
module vregfile_banked #(
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned VLEN       = 128,
    parameter int unsigned LANE_WIDTH = 32,
    parameter int unsigned NUM_RD     = 2,
    localparam int unsigned AW        = $clog2(NUM_REGS),
    localparam int unsigned BEATS     = VLEN / LANE_WIDTH,
    localparam int unsigned BCW       = $clog2(BEATS),
    localparam int unsigned BW        = LANE_WIDTH / 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_RD-1:0]                rd_req_valid_i,
    input  logic [NUM_RD-1:0][AW-1:0]        rd_req_addr_i,
    output logic [NUM_RD-1:0]                rd_req_ready_o,
    output logic [NUM_RD-1:0]                rd_valid_o,
    output logic [NUM_RD-1:0][LANE_WIDTH-1:0] rd_data_o,
    output logic [NUM_RD-1:0][BCW-1:0]       rd_beat_o,
    output logic [NUM_RD-1:0]                rd_last_o,
    input  logic [NUM_RD-1:0]                rd_ready_i,
    input  logic                             wr_valid_i,
    input  logic [AW-1:0]                    wr_addr_i,
    input  logic [LANE_WIDTH-1:0]            wr_data_i,
    input  logic [BW-1:0]                    wr_be_i,
    output logic                             wr_ready_o,
    output logic                             wr_done_o
);

    typedef enum logic {RD_IDLE, RD_STREAM} rd_state_t;
    typedef enum logic {WR_IDLE, WR_BURST}  wr_state_t;

    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

    logic [NUM_REGS-1:0][BEATS-1:0][LANE_WIDTH-1:0] mem;
    logic                       init_done;
    logic [NUM_RD-1:0]          rd_streaming;
    logic [NUM_RD-1:0][AW-1:0]  rd_addr_q;
    wr_state_t                  wr_state;
    logic [AW-1:0]              wr_addr_q;
    logic [BCW-1:0]             wr_beat_q;
    logic                       wr_hazard;
    logic                       wr_fire;
    logic [AW-1:0]              wr_word_addr;
    logic [BCW-1:0]             wr_word_beat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) init_done <= 1'b0;
        else        init_done <= 1'b1;
    end

    always_comb begin
        rd_req_ready_o = '0;
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            rd_req_ready_o[p] = !rd_streaming[p] && init_done &&
                                !(wr_state == WR_BURST && wr_addr_q == rd_req_addr_i[p]);
        end
    end

    // A read accepted this cycle wins over a first write beat to the same register.
    always_comb begin
        wr_hazard = 1'b0;
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            if ((rd_streaming[p] && rd_addr_q[p] == wr_addr_i) ||
                (rd_req_valid_i[p] && rd_req_ready_o[p] && rd_req_addr_i[p] == wr_addr_i))
                wr_hazard = 1'b1;
        end
    end

    assign wr_ready_o   = (wr_state == WR_BURST) || (init_done && !wr_hazard);
    assign wr_fire      = wr_valid_i && wr_ready_o;
    assign wr_word_addr = (wr_state == WR_BURST) ? wr_addr_q : wr_addr_i;
    assign wr_word_beat = (wr_state == WR_BURST) ? wr_beat_q : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state  <= WR_IDLE;
            wr_addr_q <= '0;
            wr_beat_q <= '0;
            wr_done_o <= 1'b0;
            mem       <= '0;
        end else begin
            wr_done_o <= 1'b0;
            if (wr_fire) begin
                for (int unsigned b = 0; b < BW; b++) begin
                    if (wr_be_i[b])
                        mem[wr_word_addr][wr_word_beat][8*b +: 8] <= wr_data_i[8*b +: 8];
                end
                if (wr_state == WR_IDLE) begin
                    wr_state  <= WR_BURST;
                    wr_addr_q <= wr_addr_i;
                    wr_beat_q <= BCW'(1);
                end else if (wr_beat_q == LAST_BEAT) begin
                    wr_state  <= WR_IDLE;
                    wr_beat_q <= '0;
                    wr_done_o <= 1'b1;
                end else begin
                    wr_beat_q <= wr_beat_q + BCW'(1);
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        rd_state_t             state;
        logic [AW-1:0]         addr_q;
        logic [BCW-1:0]        beat_q;
        logic                  valid_q;
        logic [LANE_WIDTH-1:0] data_q;

        // Each beat is fetched at the handshake that launches it, so rd_data_o holds under stall.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state   <= RD_IDLE;
                addr_q  <= '0;
                beat_q  <= '0;
                valid_q <= 1'b0;
                data_q  <= '0;
            end else begin
                case (state)
                    RD_IDLE: begin
                        if (rd_req_valid_i[p] && rd_req_ready_o[p]) begin
                            state   <= RD_STREAM;
                            addr_q  <= rd_req_addr_i[p];
                            beat_q  <= '0;
                            valid_q <= 1'b1;
                            data_q  <= mem[rd_req_addr_i[p]][0];
                        end
                    end
                    RD_STREAM: begin
                        if (rd_ready_i[p]) begin
                            if (beat_q == LAST_BEAT) begin
                                state   <= RD_IDLE;
                                beat_q  <= '0;
                                valid_q <= 1'b0;
                            end else begin
                                beat_q <= beat_q + BCW'(1);
                                data_q <= mem[addr_q][beat_q + BCW'(1)];
                            end
                        end
                    end
                    default: state <= RD_IDLE;
                endcase
            end
        end

        assign rd_streaming[p] = (state == RD_STREAM);
        assign rd_addr_q[p]    = addr_q;
        assign rd_valid_o[p]   = valid_q;
        assign rd_data_o[p]    = data_q;
        assign rd_beat_o[p]    = beat_q;
        assign rd_last_o[p]    = valid_q && (beat_q == LAST_BEAT);
    end

endmodule

// File: doc/vregfile_banked.md
# vregfile_banked

Parametrised vector register file for the vector datapath. It holds NUM_REGS registers of VLEN bits each and moves them in LANE_WIDTH-bit beats. Each of NUM_RD read ports sequences a whole register out over BEATS cycles under valid/ready flow control. A single write port accepts beats with byte enables. Hazard interlocks keep a read from overlapping an in-flight write to the same register, and the reverse.

## Interface
- NUM_REGS, 32: number of vector registers; address width AW = $clog2(NUM_REGS).
- VLEN, 128: bits per register; must be a multiple of LANE_WIDTH.
- LANE_WIDTH, 32: bits per beat; must be a multiple of 8. BEATS = VLEN/LANE_WIDTH, must be at least 2. BW = LANE_WIDTH/8.
- NUM_RD, 2: number of read ports.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rd_req_valid_i  in  NUM_RD  read request per port.
- rd_req_addr_i  in  NUM_RD x AW  source register per port.
- rd_req_ready_o  out  NUM_RD  port accepts a request.
- rd_valid_o  out  NUM_RD  beat valid.
- rd_data_o  out  NUM_RD x LANE_WIDTH  beat data.
- rd_beat_o  out  NUM_RD x $clog2(BEATS)  index of the current beat.
- rd_last_o  out  NUM_RD  current beat is BEATS-1.
- rd_ready_i  in  NUM_RD  consumer takes the beat.
- wr_valid_i  in  1  write beat valid.
- wr_addr_i  in  AW  destination register; must be held constant for the whole burst.
- wr_data_i  in  LANE_WIDTH  write beat data.
- wr_be_i  in  BW  byte enables for the beat.
- wr_ready_o  out  1  write beat accepted.
- wr_done_o  out  1  one-cycle pulse after the final beat is written.

## Operation
- Storage: NUM_REGS x BEATS words of LANE_WIDTH bits.
- No register is hardwired to zero. v0 is an ordinary register.
- Read port FSM, per port:
  - IDLE -> STREAM on a request handshake (rd_req_valid_i & rd_req_ready_o). Latch the address; set beat counter to 0.
  - STREAM: rd_valid_o=1. On rd_valid_o & rd_ready_i the counter increments.
  - On the handshake of the last beat, STREAM -> IDLE.
  - rd_req_ready_o = IDLE & init_done & no read hazard.
- Write FSM:
  - IDLE -> BURST on the first beat handshake. Latch wr_addr_i; beat counter = 1.
  - Each handshake writes word [addr][beat] with byte granularity per wr_be_i.
  - The handshake on beat BEATS-1 returns the FSM to IDLE and pulses wr_done_o on the next cycle.
  - wr_be_i = 0 consumes a beat without modifying data.
- Read hazard: a request to register R is blocked while the write FSM is in BURST with latched address R.
- Write hazard: a first write beat to R is blocked (wr_ready_o=0) while any read port is in STREAM on R.
- Write hazard, same cycle: if a request to R is accepted in the same cycle, the read wins and the write is stalled.
- Write beats after the first are never stalled; wr_ready_o=1 throughout BURST.
- Multiple read ports may stream the same register concurrently.
- Any port may be in the middle of a burst when rst_n asserts. The burst is abandoned and every FSM returns to IDLE.
- Words already written by the abandoned burst are cleared by the reset; all storage resets to 0.

## Timing
- Reset values: rd_req_ready_o=0, rd_valid_o=0, rd_data_o=0, rd_beat_o=0, rd_last_o=0, wr_ready_o=0, wr_done_o=0. All storage = 0.
- init_done is a flop set on the first edge after rst_n deasserts. Ready outputs rise from the following cycle.
- Read latency:
  - Request accepted at edge E; beat 0 is valid during the cycle after E.
  - rd_data_o is registered and holds steady while rd_valid_o & !rd_ready_i.
- With rd_ready_i held high, a read takes BEATS consecutive cycles of valid data.
- rd_req_ready_o reasserts the cycle after the last beat's handshake. This gives one bubble between back-to-back reads.
- A write beat is visible to any read beat launched after its handshake edge. A read blocked by the hazard sees the fully written register.
- wr_done_o goes high exactly one cycle after the final write handshake.

## Test plan
Bench configuration: VLEN=128, LANE_WIDTH=32, BEATS=4.
- Reset release: all ready outputs = 0 during reset and on the first edge after release, then 1. Read of v5 -> four beats 0x00000000, rd_last_o on beat 3.
- Write v3 with beats 0x11111111, 0x22222222, 0x33333333, 0x44444444, wr_be_i=0xF -> wr_done_o pulse. Read v3 port 0 -> same beats in order, rd_beat_o 0..3.
- Byte enables: write v3 beat 0 = 0xAABBCCDD with be=0x5 -> read beat 0 = 0x11BB11DD.
- Backpressure: toggle rd_ready_i 1,0,0,1,... during a read -> data stable while stalled, no beat skipped or repeated.
- Hazards:
  - Write v7 in BURST at beat 1; request v7 on port 1 -> rd_req_ready_o=0 until the burst ends, then new data returned.
  - Port 0 streaming v7 -> first write beat to v7 stalls until rd_last_o is accepted.
  - Read and write to v7 in the same cycle -> read wins and returns the old data.
- Reset mid-burst: assert rst_n low during write beat 2 and during read beat 1 -> all outputs return to reset values; a subsequent read returns zeros.
